// File: rtl/fetcher_if.sv
// Instruction-memory read bus: valid/ready address channel plus valid/ready data channel.
interface fetcher_if;
   logic [31:0] mem_araddr;
   logic        mem_arvalid;
   logic        mem_arready;
   logic [31:0] mem_rdata;
   logic        mem_rerr;
   logic        mem_rvalid;
   logic        mem_rready;

   modport master (
      output mem_araddr,
      output mem_arvalid,
      input  mem_arready,
      input  mem_rdata,
      input  mem_rerr,
      input  mem_rvalid,
      output mem_rready
   );

   modport slave (
      input  mem_araddr,
      input  mem_arvalid,
      output mem_arready,
      output mem_rdata,
      output mem_rerr,
      output mem_rvalid,
      input  mem_rready
   );
endinterface

// File: rtl/fetcher.sv
// Instruction fetch stage: one bus read per `enabled` pulse, with alignment check, flush,
// bus-error and response-timeout handling; faulted fetches deliver NOP_INSTR.
module fetcher #(
   parameter int unsigned TIMEOUT   = 1024,
   parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
   input  logic             clk,
   input  logic             rstn,
   input  logic             enabled,
   input  logic             flush,
   input  logic [31:0]      pc,
   output logic             completed,
   output logic             busy,
   output logic [31:0]      instr_raw,
   output logic [31:0]      pc_out,
   output logic             exc_misaligned,
   output logic             exc_access_fault,
   fetcher_if.master        mem
);

   localparam int unsigned CntW = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;

   typedef enum logic [2:0] {StIdle, StAddr, StData, StFault, StDrain} state_e;

   state_e            state_q, state_d;
   logic              completed_q, completed_d;
   logic              busy_q, busy_d;
   logic [31:0]       instr_q, instr_d;
   logic [31:0]       pc_out_q, pc_out_d;
   logic              mis_q, mis_d;
   logic              acc_q, acc_d;
   logic [31:0]       araddr_q, araddr_d;
   logic              arvalid_q, arvalid_d;
   logic              rready_q, rready_d;
   logic [CntW-1:0]   cnt_q, cnt_d;
   logic              pend_q, pend_d;

   always_comb begin
      state_d     = state_q;
      completed_d = 1'b0;
      instr_d     = instr_q;
      pc_out_d    = pc_out_q;
      mis_d       = mis_q;
      acc_d       = acc_q;
      araddr_d    = araddr_q;
      arvalid_d   = arvalid_q;
      rready_d    = rready_q;
      cnt_d       = cnt_q;
      pend_d      = pend_q;

      case (state_q)
         StIdle: begin
            pend_d = 1'b0;
            if (enabled) begin
               pc_out_d = pc;
               acc_d    = 1'b0;
               mis_d    = (pc[1:0] != 2'b00);
               if (pc[1:0] != 2'b00) begin
                  state_d = StFault;
               end else begin
                  araddr_d  = {pc[31:2], 2'b00};
                  arvalid_d = 1'b1;
                  state_d   = StAddr;
               end
            end
         end
         StAddr: begin
            // The address cannot be withdrawn, so a flush here is remembered until the handshake.
            if (flush) pend_d = 1'b1;
            if (mem.mem_arready) begin
               arvalid_d = 1'b0;
               rready_d  = 1'b1;
               cnt_d     = '0;
               pend_d    = 1'b0;
               state_d   = (pend_q || flush) ? StDrain : StData;
            end
         end
         StData: begin
            if (flush) begin
               if (mem.mem_rvalid) begin
                  rready_d = 1'b0;
                  state_d  = StIdle;
               end else begin
                  state_d = StDrain;
               end
            end else if (mem.mem_rvalid) begin
               instr_d     = mem.mem_rerr ? NOP_INSTR : mem.mem_rdata;
               acc_d       = mem.mem_rerr;
               completed_d = 1'b1;
               rready_d    = 1'b0;
               state_d     = StIdle;
            end else if ((TIMEOUT != 0) && (cnt_q == CntW'(TIMEOUT - 1))) begin
               // Give up on this cycle so the fault completes after exactly TIMEOUT waits.
               instr_d     = NOP_INSTR;
               acc_d       = 1'b1;
               completed_d = 1'b1;
               state_d     = StDrain;
            end else begin
               cnt_d = cnt_q + CntW'(1);
            end
         end
         StFault: begin
            if (!flush) begin
               instr_d     = NOP_INSTR;
               completed_d = 1'b1;
            end
            state_d = StIdle;
         end
         StDrain: begin
            rready_d = 1'b1;
            if (mem.mem_rvalid) begin
               rready_d = 1'b0;
               state_d  = StIdle;
            end
         end
         default: begin
            state_d   = StIdle;
            arvalid_d = 1'b0;
            rready_d  = 1'b0;
         end
      endcase

      busy_d = (state_d != StIdle);
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state_q     <= StIdle;
         completed_q <= 1'b0;
         busy_q      <= 1'b0;
         instr_q     <= '0;
         pc_out_q    <= '0;
         mis_q       <= 1'b0;
         acc_q       <= 1'b0;
         araddr_q    <= '0;
         arvalid_q   <= 1'b0;
         rready_q    <= 1'b0;
         cnt_q       <= '0;
         pend_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         completed_q <= completed_d;
         busy_q      <= busy_d;
         instr_q     <= instr_d;
         pc_out_q    <= pc_out_d;
         mis_q       <= mis_d;
         acc_q       <= acc_d;
         araddr_q    <= araddr_d;
         arvalid_q   <= arvalid_d;
         rready_q    <= rready_d;
         cnt_q       <= cnt_d;
         pend_q      <= pend_d;
      end
   end

   assign completed        = completed_q;
   assign busy             = busy_q;
   assign instr_raw        = instr_q;
   assign pc_out           = pc_out_q;
   assign exc_misaligned   = mis_q;
   assign exc_access_fault = acc_q;
   assign mem.mem_araddr   = araddr_q;
   assign mem.mem_arvalid  = arvalid_q;
   assign mem.mem_rready   = rready_q;

endmodule

// File: doc/fetcher.md
Name: fetcher

Overview:
- Instruction fetch stage that drives the decoder's `enabled`/`pc`/`instr_raw` inputs.
- On an `enabled` pulse it:
  - latches the target PC;
  - checks alignment;
  - performs one read on the instruction-memory bus (valid/ready address and data channels);
  - returns the raw 32-bit word with a one-cycle `completed` pulse.
- Handles flush of in-flight fetches, bus errors and response timeouts without ever handing stale words to the decoder.

Parameters:
- TIMEOUT, 1024: max cycles waiting for `mem_rvalid` after the address is accepted; 0 disables the timeout.
- NOP_INSTR, 32'h00000013: word driven on `instr_raw` when a fetch completes with a fault.

Ports:
- clk  input  1  clock
- rstn  input  1  asynchronous active-low reset
- enabled  input  1  start a fetch; sampled only in IDLE
- flush  input  1  abort the outstanding fetch; its result is discarded
- pc  input  32  fetch address, sampled with `enabled`
- completed  output  1  one-cycle pulse: `instr_raw`, `pc_out` and the fault flags are valid
- busy  output  1  high in every state except IDLE
- instr_raw  output  32  fetched instruction word
- pc_out  output  32  address of the word on `instr_raw`
- exc_misaligned  output  1  `pc[1:0]` != 0; qualified by `completed`
- exc_access_fault  output  1  bus error or timeout; qualified by `completed`
- mem_araddr  output  32  read address, word aligned
- mem_arvalid  output  1  address valid
- mem_arready  input  1  address accepted
- mem_rdata  input  32  read data
- mem_rerr  input  1  read error, qualified by `mem_rvalid`
- mem_rvalid  input  1  data valid
- mem_rready  output  1  data accept

Behaviour:
- Reset (`rstn` low, takes effect immediately):
  - state IDLE;
  - `completed`, `busy`, `mem_arvalid`, `mem_rready`, `exc_misaligned`, `exc_access_fault` = 0;
  - `instr_raw`, `pc_out`, `mem_araddr` = 0;
  - timeout counter = 0.
- Reset mid-transaction abandons the fetch; the memory side is reset by the same `rstn`.
- States: IDLE, ADDR, DATA, FAULT, DRAIN.
- IDLE, on `enabled`:
  - latch `pc` into `pc_out`.
  - If `pc[1:0]` != 0, go to FAULT with `exc_misaligned` set; no bus request.
  - Otherwise set `mem_araddr` = `pc`, `mem_arvalid` = 1, go to ADDR.
- `enabled` is ignored whenever `busy` = 1; there is no queuing.
- ADDR:
  - hold `mem_arvalid` and `mem_araddr` stable until `mem_arready`;
  - on handshake: `mem_arvalid` = 0, `mem_rready` = 1, clear the counter, go to DATA (or to DRAIN if flush is pending).
- DATA:
  - the counter increments each cycle without `mem_rvalid`.
  - On `mem_rvalid`:
    - `instr_raw` = `mem_rdata` (`NOP_INSTR` if `mem_rerr`);
    - `exc_access_fault` = `mem_rerr`;
    - `completed` pulses next cycle;
    - `mem_rready` = 0; go to IDLE.
  - If `TIMEOUT` != 0 and the counter reaches `TIMEOUT`:
    - `completed` pulses with `exc_access_fault` = 1 and `instr_raw` = `NOP_INSTR`;
    - go to DRAIN.
- FAULT:
  - `instr_raw` = `NOP_INSTR`; `completed` pulses for one cycle; return to IDLE.
- DRAIN:
  - `mem_rready` = 1; the next `mem_rvalid` is consumed silently (no `completed`); then go to IDLE.
- Flush:
  - IDLE: no effect.
  - FAULT: suppress the completion; go to IDLE.
  - ADDR: the address must still complete its handshake (no withdrawal of `arvalid`); a pending-flush bit is set, and DRAIN follows the handshake.
  - DATA: go to DRAIN; if `mem_rvalid` arrives in the same cycle, the word is discarded and the FSM goes to IDLE.
  - `flush` has priority over completion and timeout in the same cycle.
- Minimum latency, `enabled` at edge N:
  - `arvalid` high in N+1;
  - `arready` in N+1 gives `rready` in N+2;
  - `rvalid` in N+2 gives `completed` in N+3.
- Misaligned fetch: `completed` at N+2.
- Fault flags clear at the start of every new fetch; `instr_raw`, `pc_out` and the flags otherwise hold until the next completion.
- `completed` is never high for two consecutive cycles.

Test Plan:
- `pc`=0x100, `arready`=1 and `rvalid`=1 the cycle after accept, `rdata`=0x00A00093 → `completed` at N+3, `instr_raw`=0x00A00093, `pc_out`=0x100, no faults.
- `pc`=0x102 → no `arvalid` ever; `completed` at N+2 with `exc_misaligned`=1, `instr_raw`=0x00000013.
- `arready` held low 5 cycles → `araddr`/`arvalid` stable throughout; `enabled` pulses during the wait are ignored; single `completed`.
- `rvalid` with `rerr`=1 → `completed`, `exc_access_fault`=1, `instr_raw`=`NOP_INSTR`.
- `TIMEOUT`=4 with no `rvalid` → `completed` with `exc_access_fault` after 4 DATA cycles; a late `rvalid` with 0xDEADBEEF is consumed; `instr_raw` never shows 0xDEADBEEF.
- `flush` in ADDR, then `flush` coincident with `rvalid` in DATA; async reset asserted in DATA → no `completed` in the flush cases; after reset every output is zero immediately.
